board_status_display: RTL
=========================

Name: board_status_display

Overview:
Parametrised board status and seven-segment display controller for the FPGA wrappers. It decodes a sampled 32-bit system value onto NUM_DIGITS hex digits. It drives one status digit with a prioritised code (lamp test, lockup, error, heartbeat) and generates the heartbeat internally. It sits in the board wrapper between the soc output port and the HEX pins, replacing hand-wired per-digit constants.

Parameters:
NUM_DIGITS, 5, number of value digits; legal range 1..8. Digit i shows nibble value[4i+3:4i].
HB_MSB, 25, MSB index of the heartbeat counter; must be >= 2.
SAMPLE_LOG2, 20, display value is re-sampled every 2^SAMPLE_LOG2 cycles; must be >= 1.
LAMP_CYCLES, 25000000, cycles of all-segments-on after reset release; must be >= 1.

Ports:
HCLK  input  1  system clock
HRESETn  input  1  asynchronous active-low reset
value  input  32  value to display (normally soc oPort)
value_valid  input  1  1 = value is meaningful; 0 = error condition
lockup  input  1  processor lockup indication
mode  input  2  0 hex, 1 hex with leading-zero blanking, 2 digits blank, 3 forced lamp test
hex_out  output  7*NUM_DIGITS  active-low segments; digit i at [7i+6:7i]; segment order g..a (bit 6 = g)
status_seg  output  7  active-low status digit segments
heartbeat  output  1  heartbeat pulse train

Behaviour:
- One clock (HCLK). Reset is asynchronous and active-low (HRESETn). All state is in HCLK flops.
- Reset values:
  - hex_out all 1s (all digits off).
  - status_seg 7'b1111111.
  - heartbeat 0.
  - FSM in LAMP.
  - Lamp, sample and heartbeat counters 0.
  - Display register 0.
  - lockup_seen 0.
- All outputs are registered. An input change appears on the outputs 1 cycle after the edge that samples it.
- FSM states:
  - LAMP: count LAMP_CYCLES cycles, then go to RUN. All segments of every digit and the status digit are lit (7'b0000000).
  - RUN: normal operation. No exit other than reset.
- Reset mid-operation returns the FSM to LAMP and clears all state immediately.
- Heartbeat:
  - Free-running (HB_MSB+1)-bit counter that wraps to 0.
  - heartbeat register <= cnt[HB_MSB] & cnt[HB_MSB-2].
  - The counter runs in LAMP and in RUN.
- Sampling:
  - SAMPLE_LOG2-bit counter. On wrap (all 1s -> 0) with value_valid = 1, the display register <= value.
  - With value_valid = 0 at the wrap, the display register holds its previous contents.
  - Sampling also runs in LAMP, so the display is current on entry to RUN.
- lockup_seen: set on any cycle with lockup = 1. It is sticky until reset.
- Status digit priority, in RUN, evaluated each cycle:
  1. mode==3: all on.
  2. lockup_seen: L.
  3. value_valid==0: E.
  4. heartbeat register = 1: o.
  5. Otherwise: off.
- Value digits in RUN:
  - mode 0: hex decode of each nibble, 0..F.
  - mode 1: digit i (i>0) is off when every nibble j >= i within NUM_DIGITS is 0. Digit 0 always shows, so 0 displays as "0".
  - mode 2: all off.
  - mode 3: all on.
- mode is sampled every cycle; a change in RUN takes effect on the next output update.
- mode is ignored in LAMP.
- Simultaneous lockup and value_valid=0: L wins.
- Simultaneous sample wrap and value_valid falling: no capture.

Decomposition:
- Shared package board_display_pkg:
  - 7-bit active-low constants SEG_0..SEG_F, SEG_L, SEG_E, SEG_o, SEG_OFF (7'h7F), SEG_ALL (7'h00).
  - Mode encodings MODE_HEX, MODE_HEX_LZB, MODE_BLANK, MODE_LAMP.
  - FSM state enum.
- Sub-module seg7_hex_decoder: combinational, 4-bit nibble -> 7-bit active-low segments. Instantiated NUM_DIGITS times via generate.

Test Plan:
Bench parameters for all scenarios: NUM_DIGITS=4, HB_MSB=4, SAMPLE_LOG2=2, LAMP_CYCLES=4.
1. Reset then release -> hex_out=28'h0000000 and status_seg=7'h00 for 4 cycles, then RUN. Digits show "0000" (SEG_0 each). Status is off or o according to heartbeat.
2. mode=0, value=32'h0000A3F1, value_valid=1 -> within 4 cycles of a sample wrap, digits 3..0 = SEG_A, SEG_3, SEG_F, SEG_1. heartbeat is 1 exactly when counter values are 20..23 and 28..31.
3. mode=1, value=32'h00000050 -> digits 3,2 off; digit 1 = SEG_5; digit 0 = SEG_0. Then value=0 -> only digit 0 shows SEG_0.
4. Display "1234", then value_valid=0 and value=32'hFFFF -> status_seg=SEG_E next cycle and digits keep "1234" across several sample wraps. Restore valid -> E clears.
5. Pulse lockup for 1 cycle -> status_seg=SEG_L from the next cycle and persists with lockup=0 and value_valid=0. Assert HRESETn=0 mid-run -> all outputs off immediately, then the lamp test repeats.
6. mode=2 -> hex_out all 1s. mode=3 -> hex_out and status_seg all 0s, overriding the lockup L.

Source files
------------

// File: rtl/board_display_pkg.sv
// Shared constants for the board status / seven-segment display controller.
// Segment patterns are 7-bit active-low, bit 6 = g ... bit 0 = a.
// Contents: SEG_0..SEG_F, SEG_L, SEG_E, SEG_o, SEG_OFF, SEG_ALL,
//           display mode encodings, controller FSM state enum.
package board_display_pkg;

    localparam logic [6:0] SEG_0   = 7'h40;
    localparam logic [6:0] SEG_1   = 7'h79;
    localparam logic [6:0] SEG_2   = 7'h24;
    localparam logic [6:0] SEG_3   = 7'h30;
    localparam logic [6:0] SEG_4   = 7'h19;
    localparam logic [6:0] SEG_5   = 7'h12;
    localparam logic [6:0] SEG_6   = 7'h02;
    localparam logic [6:0] SEG_7   = 7'h78;
    localparam logic [6:0] SEG_8   = 7'h00;
    localparam logic [6:0] SEG_9   = 7'h10;
    localparam logic [6:0] SEG_A   = 7'h08;
    localparam logic [6:0] SEG_B   = 7'h03;
    localparam logic [6:0] SEG_C   = 7'h46;
    localparam logic [6:0] SEG_D   = 7'h21;
    localparam logic [6:0] SEG_E   = 7'h06;
    localparam logic [6:0] SEG_F   = 7'h0E;
    localparam logic [6:0] SEG_L   = 7'h47;
    localparam logic [6:0] SEG_o   = 7'h23;
    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [6:0] SEG_ALL = 7'h00;

    localparam logic [1:0] MODE_HEX     = 2'd0;
    localparam logic [1:0] MODE_HEX_LZB = 2'd1;
    localparam logic [1:0] MODE_BLANK   = 2'd2;
    localparam logic [1:0] MODE_LAMP    = 2'd3;

    typedef enum logic {
        ST_LAMP = 1'b0,
        ST_RUN  = 1'b1
    } disp_state_e;

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to seven-segment decoder.
// Ports: nibble [3:0] in  - value 0..F
//        seg    [6:0] out - active-low segments, bit 6 = g
module seg7_hex_decoder
    import board_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/board_status_display.sv
// Board status and seven-segment display controller.
// After reset a lamp test lights every segment for LAMP_CYCLES cycles, then
// the value digits show a periodically sampled 32-bit value and the status
// digit shows the highest-priority condition (lamp, lockup, error, heartbeat).
// Ports:
//   HCLK, HRESETn         clock, async active-low reset
//   value[31:0]           value to display
//   value_valid           0 flags an error and blocks sampling
//   lockup                processor lockup (latched until reset)
//   mode[1:0]             0 hex, 1 hex + leading-zero blank, 2 blank, 3 lamp
//   hex_out[7*ND-1:0]     active-low digits, digit i at [7i+6:7i]
//   status_seg[6:0]       active-low status digit
//   heartbeat             heartbeat pulse train
module board_status_display
    import board_display_pkg::*;
#(
    parameter int NUM_DIGITS  = 5,
    parameter int HB_MSB      = 25,
    parameter int SAMPLE_LOG2 = 20,
    parameter int LAMP_CYCLES = 25000000
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic [31:0]             value,
    input  logic                    value_valid,
    input  logic                    lockup,
    input  logic [1:0]              mode,
    output logic [7*NUM_DIGITS-1:0] hex_out,
    output logic [6:0]              status_seg,
    output logic                    heartbeat
);

    localparam int LAMP_W = (LAMP_CYCLES > 1) ? $clog2(LAMP_CYCLES) : 1;

    disp_state_e            state, state_nxt;
    logic [LAMP_W-1:0]      lamp_cnt;
    logic                   lamp_done;
    logic [HB_MSB:0]        hb_cnt;
    logic [SAMPLE_LOG2-1:0] samp_cnt;
    logic [31:0]            disp_reg;
    logic                   lockup_seen;

    logic [NUM_DIGITS-1:0][6:0] dec_seg;
    logic [NUM_DIGITS-1:0][6:0] hex_nxt;
    logic [NUM_DIGITS:0]        upper_nz;
    logic [6:0]                 status_nxt;

    // Digits above NUM_DIGITS are captured but never shown.
    logic unused_disp;
    assign unused_disp = ^disp_reg;

    // ---------------- FSM ----------------
    assign lamp_done = (lamp_cnt == LAMP_W'(LAMP_CYCLES - 1));

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= ST_LAMP;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_LAMP: if (lamp_done) state_nxt = ST_RUN;
            ST_RUN:  state_nxt = ST_RUN;
            default: state_nxt = ST_LAMP;
        endcase
    end

    // ---------------- counters and captured state ----------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            lamp_cnt    <= '0;
            hb_cnt      <= '0;
            samp_cnt    <= '0;
            disp_reg    <= '0;
            lockup_seen <= 1'b0;
            heartbeat   <= 1'b0;
        end else begin
            if (state == ST_LAMP && !lamp_done)
                lamp_cnt <= lamp_cnt + 1'b1;
            hb_cnt    <= hb_cnt + 1'b1;
            heartbeat <= hb_cnt[HB_MSB] & hb_cnt[HB_MSB-2];
            samp_cnt  <= samp_cnt + 1'b1;
            // Capture on the wrap only; an invalid value keeps the old display.
            if (&samp_cnt && value_valid)
                disp_reg <= value;
            if (lockup)
                lockup_seen <= 1'b1;
        end
    end

    // ---------------- digit decode ----------------
    // upper_nz[i] = some nibble at index >= i is non-zero (leading-zero blanking)
    assign upper_nz[NUM_DIGITS] = 1'b0;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        seg7_hex_decoder u_dec (
            .nibble (disp_reg[4*g +: 4]),
            .seg    (dec_seg[g])
        );
        assign upper_nz[g] = upper_nz[g+1] | (|disp_reg[4*g +: 4]);
    end

    always_comb begin
        hex_nxt = dec_seg;
        if (state == ST_LAMP) begin
            hex_nxt = '0;
        end else begin
            case (mode)
                MODE_HEX:     hex_nxt = dec_seg;
                MODE_HEX_LZB: begin
                    // digit 0 never blanks so a zero value still reads "0"
                    for (int i = 1; i < NUM_DIGITS; i++)
                        if (!upper_nz[i]) hex_nxt[i] = SEG_OFF;
                end
                MODE_BLANK:   hex_nxt = '1;
                MODE_LAMP:    hex_nxt = '0;
                default:      hex_nxt = dec_seg;
            endcase
        end
    end

    // ---------------- status digit ----------------
    // Live lockup is ORed in so L shows on the edge that first sees it.
    always_comb begin
        status_nxt = SEG_OFF;
        if (state == ST_LAMP || mode == MODE_LAMP) status_nxt = SEG_ALL;
        else if (lockup_seen || lockup)            status_nxt = SEG_L;
        else if (!value_valid)                     status_nxt = SEG_E;
        else if (heartbeat)                        status_nxt = SEG_o;
        else                                       status_nxt = SEG_OFF;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hex_out    <= '1;
            status_seg <= SEG_OFF;
        end else begin
            hex_out    <= hex_nxt;
            status_seg <= status_nxt;
        end
    end

endmodule
